// File: rtl/core_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu_pkg
// Description : Shared types and helper functions for the load/store unit:
//               access-size and FSM-state encodings, misalignment detection,
//               address force-alignment, byte-enable generation and store
//               lane replication. All helpers assume a 32-bit data path.
// Revision    : 1.0 - initial release
// ============================================================================
package core_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_e;

    // The reserved size encoding (2'b11) is always treated as misaligned.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        case (size)
            LSU_BYTE: r = 1'b0;
            LSU_HALF: r = addr_lo[0];
            LSU_WORD: r = (addr_lo != 2'b00);
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

    // The reserved size is carried through the pipeline as a word access.
    function automatic lsu_size_e lsu_eff_size(input logic [1:0] size);
        return (size == 2'b11) ? LSU_WORD : lsu_size_e'(size);
    endfunction

    // Low address bits after rounding down to the natural boundary of the size.
    function automatic logic [1:0] lsu_align_lo(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] r;
        case (size)
            LSU_BYTE: r = addr_lo;
            LSU_HALF: r = {addr_lo[1], 1'b0};
            default:  r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lsu_byte_enable(input lsu_size_e size, input logic [1:0] addr_lo);
        logic [3:0] r;
        case (size)
            LSU_BYTE: r = 4'b0001 << addr_lo;
            LSU_HALF: r = 4'b0011 << addr_lo;
            default:  r = 4'b1111;
        endcase
        return r;
    endfunction

    // Replicating the store value into every lane lets the byte enables alone
    // select the written bytes, with no shifter on the store path.
    function automatic logic [31:0] lsu_store_data(input lsu_size_e size, input logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            LSU_BYTE: r = {4{wdata[7:0]}};
            LSU_HALF: r = {2{wdata[15:0]}};
            default:  r = wdata;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu_align
// Description : Combinational load-data alignment. Shifts the memory word
//               right by the byte offset, then sign- or zero-extends the
//               byte/half/word result.
// Ports       : rdata_i    - raw read data from memory
//               offset_i   - byte offset within the word
//               size_i     - effective access size
//               unsigned_i - zero-extend instead of sign-extend
//               data_o     - aligned, extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module core_lsu_align
    import core_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            offset_i,
    input  lsu_size_e             size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = w_shifted;
        case (size_i)
            LSU_BYTE: data_o = unsigned_i ? {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]}
                                          : {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            LSU_HALF: data_o = unsigned_i ? {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]}
                                          : {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            default:  data_o = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/core_lsu.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu
// Description : Load/store unit. Accepts one memory op from the execution
//               stage, runs a single request/grant/rvalid transaction to data
//               memory and returns a one-cycle completion to writeback. Only
//               one access is outstanding at a time.
// Ports       : clk_i, rst_ni            - clock, async active-low reset
//               ex_*/addr_i/wdata_i/...  - op from the execution stage
//               data_*                   - memory request/response interface
//               wb_*                     - registered completion to writeback
// Config      : CORE_LSU_MISALIGN_TRAP_EN - when defined, misaligned ops
//               complete next cycle with wb_err_o and no memory access; when
//               undefined, the address is force-aligned to the access size.
// Revision    : 1.0 - initial release
// ============================================================================
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ex_valid_i,
    output logic                      ex_ready_o,
    input  logic [DATA_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic                      we_i,
    input  logic [1:0]                size_i,
    input  logic                      unsigned_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    output logic [DATA_WIDTH-1:0]     data_addr_o,
    output logic                      data_we_o,
    output logic [DATA_WIDTH/8-1:0]   data_be_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    input  logic                      data_err_i,
    output logic                      wb_valid_o,
    output logic                      wb_load_o,
    output logic [DATA_WIDTH-1:0]     wb_rdata_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
    output logic                      wb_err_o
);

`ifdef CORE_LSU_MISALIGN_TRAP_EN
    localparam logic c_trap_en = 1'b1;
`else
    localparam logic c_trap_en = 1'b0;
`endif

    lsu_state_e                r_state;
    logic                      r_req;
    logic [DATA_WIDTH-1:0]     r_addr;
    logic                      r_we;
    logic [DATA_WIDTH/8-1:0]   r_be;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [1:0]                r_offset;
    lsu_size_e                 r_size;
    logic                      r_unsigned;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      r_wb_valid;
    logic                      r_wb_load;
    logic [DATA_WIDTH-1:0]     r_wb_rdata;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
    logic                      r_wb_err;

    logic                      w_accept;
    logic                      w_misaligned;
    lsu_size_e                 w_eff_size;
    logic [1:0]                w_lo;
    logic [DATA_WIDTH-1:0]     w_load_data;

    assign ex_ready_o   = (r_state == IDLE);
    assign w_accept     = ex_valid_i & ex_ready_o;
    assign w_misaligned = lsu_misaligned(size_i, addr_i[1:0]);
    assign w_eff_size   = lsu_eff_size(size_i);
    // For aligned ops this is just addr_i[1:0]; it only differs when the
    // address has to be rounded down.
    assign w_lo         = lsu_align_lo(size_i, addr_i[1:0]);

    core_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .rdata_i    (data_rdata_i),
        .offset_i   (r_offset),
        .size_i     (r_size),
        .unsigned_i (r_unsigned),
        .data_o     (w_load_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_offset   <= 2'b00;
            r_size     <= LSU_BYTE;
            r_unsigned <= 1'b0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_load  <= 1'b0;
            r_wb_rdata <= '0;
            r_wb_rd    <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we       <= we_i;
                        r_size     <= w_eff_size;
                        r_offset   <= w_lo;
                        r_unsigned <= unsigned_i;
                        r_rd       <= rd_i;
                        if (c_trap_en && w_misaligned) begin
                            // Fault without touching memory; stay ready.
                            r_wb_valid <= 1'b1;
                            r_wb_load  <= ~we_i;
                            r_wb_err   <= 1'b1;
                            r_wb_rdata <= '0;
                            r_wb_rd    <= rd_i;
                        end else begin
                            r_req   <= 1'b1;
                            r_addr  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                            r_be    <= lsu_byte_enable(w_eff_size, w_lo);
                            r_wdata <= lsu_store_data(w_eff_size, wdata_i);
                            r_state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_rvalid_i) begin
                        r_wb_valid <= 1'b1;
                        r_wb_load  <= ~r_we;
                        r_wb_err   <= data_err_i;
                        r_wb_rdata <= (r_we || data_err_i) ? '0 : w_load_data;
                        r_wb_rd    <= r_rd;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_req_o   = r_req;
    assign data_addr_o  = r_addr;
    assign data_we_o    = r_we;
    assign data_be_o    = r_be;
    assign data_wdata_o = r_wdata;
    assign wb_valid_o   = r_wb_valid;
    assign wb_load_o    = r_wb_load;
    assign wb_rdata_o   = r_wb_rdata;
    assign wb_rd_o      = r_wb_rd;
    assign wb_err_o     = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_core_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_lsu
// Description : Self-checking bench for core_lsu. Directed cases for the
//               documented scenarios followed by randomized ops, each
//               checked against a byte-arithmetic reference model.
//               Honours CORE_LSU_MISALIGN_TRAP_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        unsgn;
    logic [4:0]  rd;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        wb_valid;
    logic        wb_load;
    logic [31:0] wb_rdata;
    logic [4:0]  wb_rd;
    logic        wb_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_lsu #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ex_valid_i    (ex_valid),
        .ex_ready_o    (ex_ready),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .we_i          (we),
        .size_i        (size),
        .unsigned_i    (unsgn),
        .rd_i          (rd),
        .data_req_o    (data_req),
        .data_gnt_i    (data_gnt),
        .data_addr_o   (data_addr),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_wdata_o  (data_wdata),
        .data_rvalid_i (data_rvalid),
        .data_rdata_i  (data_rdata),
        .data_err_i    (data_err),
        .wb_valid_o    (wb_valid),
        .wb_load_o     (wb_load),
        .wb_rdata_o    (wb_rdata),
        .wb_rd_o       (wb_rd),
        .wb_err_o      (wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int m_nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_align(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        nb = m_nbytes(sz);
        return a - (a % nb);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] ea);
        int nb;
        int v;
        nb = m_nbytes(sz);
        v  = ((1 << nb) - 1) << (ea % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        longint b;
        if (sz == 2'd0) begin
            b = longint'(w) % 256;
            return 32'(b * 64'h01010101);
        end
        if (sz == 2'd1) begin
            b = longint'(w) % 65536;
            return 32'(b * 64'h00010001);
        end
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdat, input logic [31:0] ea,
                                           input logic [1:0] sz, input logic u);
        longint v;
        longint m;
        int     nb;
        nb = m_nbytes(sz);
        v  = longint'(rdat) / (longint'(1) << (8 * (ea % 4)));
        m  = longint'(1) << (8 * nb);
        v  = v % m;
        if (!u && nb < 4 && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    // ---------------- one op through the unit ----------------
    task automatic do_op(input logic [31:0] a, input logic [31:0] w, input logic st,
                         input logic [1:0] sz, input logic u, input logic [4:0] tag,
                         input int gdly, input int rdly, input logic [31:0] rdat, input logic e);
        logic [31:0] ea;
        logic [31:0] exp_rd;
        chk("ex_ready_before_op", ex_ready, 1);
        addr = a; wdata = w; we = st; size = sz; unsgn = u; rd = tag; ex_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        addr = $urandom; wdata = $urandom; we = $urandom_range(0, 1); size = 2'($urandom_range(0, 3));
        rd = 5'($urandom);
`ifdef CORE_LSU_MISALIGN_TRAP_EN
        if (m_misaligned(sz, a)) begin
            chk("trap_no_req", data_req, 0);
            chk("trap_wb_valid", wb_valid, 1);
            chk("trap_wb_err", wb_err, 1);
            chk("trap_wb_rdata", wb_rdata, 0);
            chk("trap_wb_rd", wb_rd, tag);
            chk("trap_ex_ready", ex_ready, 1);
            @(negedge clk);
            chk("trap_pulse_end", wb_valid, 0);
            return;
        end
`endif
        ea = m_align((sz == 2'd3) ? 2'd2 : sz, a);
        for (int i = 0; i <= gdly; i++) begin
            if (i > 0) begin
                data_rvalid = 1'b0;
                @(negedge clk);
            end
            chk("req_high", data_req, 1);
            chk("req_addr", data_addr, {ea[31:2], 2'b00});
            chk("req_be", data_be, m_be((sz == 2'd3) ? 2'd2 : sz, ea));
            chk("req_we", data_we, st);
            if (st) chk("req_wdata", data_wdata, m_wdata((sz == 2'd3) ? 2'd2 : sz, w));
            chk("ex_ready_busy", ex_ready, 0);
            chk("no_wb_in_req", wb_valid, 0);
            // stray response while still requesting must be ignored
            if (i < gdly) data_rvalid = 1'($urandom_range(0, 1));
        end
        data_rvalid = 1'b0;
        data_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_gnt = 1'b0;
        chk("req_dropped", data_req, 0);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("no_wb_in_wait", wb_valid, 0);
            chk("ex_ready_wait", ex_ready, 0);
        end
        data_rvalid = 1'b1; data_rdata = rdat; data_err = e;
        @(negedge clk);
        data_rvalid = 1'b0; data_err = 1'b0; data_rdata = $urandom;
        exp_rd = (st || e) ? 32'd0 : m_load(rdat, ea, (sz == 2'd3) ? 2'd2 : sz, u);
        chk("wb_valid", wb_valid, 1);
        chk("wb_load", wb_load, !st);
        chk("wb_err", wb_err, e);
        chk("wb_rdata", wb_rdata, exp_rd);
        chk("wb_rd", wb_rd, tag);
        chk("ex_ready_on_wb", ex_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; addr = '0; wdata = '0; we = 1'b0; size = 2'b00;
        unsgn = 1'b0; rd = '0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        data_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_req", data_req, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_be", data_be, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_wb_rdata", wb_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // SB at 0x1003, immediate grant/response
        do_op(32'h1003, 32'h0000_00AB, 1'b1, 2'd0, 1'b0, 5'd3, 0, 0, 32'h0, 1'b0);
        // LH / LHU at 0x2002
        do_op(32'h2002, 32'h0, 1'b0, 2'd1, 1'b0, 5'd7, 0, 0, 32'h8001_1234, 1'b0);
        do_op(32'h2002, 32'h0, 1'b0, 2'd1, 1'b1, 5'd8, 0, 0, 32'h8001_1234, 1'b0);
        // LW with grant held off for 5 cycles
        do_op(32'h2FF0, 32'h0, 1'b0, 2'd2, 1'b0, 5'd9, 5, 1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("single_wb_pulse", wb_valid, 0);
        // LW with bus error
        do_op(32'h3000, 32'h0, 1'b0, 2'd2, 1'b0, 5'd21, 0, 0, 32'h1234_5678, 1'b1);
        // misaligned LW
        do_op(32'h4001, 32'h0, 1'b0, 2'd2, 1'b0, 5'd11, 0, 0, 32'hCAFE_F00D, 1'b0);

        // reset while in REQ
        @(negedge clk);
        addr = 32'h5000; size = 2'd2; we = 1'b0; rd = 5'd4; ex_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("pre_reset_req", data_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_req_drop", data_req, 0);
        chk("reset_ex_ready", ex_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        data_rvalid = 1'b1; data_rdata = 32'h5555_5555;
        @(negedge clk);
        data_rvalid = 1'b0;
        chk("late_rvalid_no_wb", wb_valid, 0);
        @(negedge clk);
        chk("late_rvalid_no_wb2", wb_valid, 0);
        chk("late_rvalid_no_req", data_req, 0);

        // randomized ops
        for (int k = 0; k < 60; k++) begin
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 2), $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_lsu.md
Name: core_lsu

Overview:
- Load/store unit directly downstream of the execution stage.
- Takes the effective address produced by the execution adder (low DATA_WIDTH bits of adder_o), plus store data and access attributes.
- Runs one OBI-style request/grant/rvalid transaction to data memory.
- Returns aligned, sign- or zero-extended load data (or store completion) to writeback. One access outstanding at a time.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- REG_ADDR_WIDTH, 5, width of the destination register tag passed through to writeback.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- ex_valid_i  input  1  execution stage presents a memory op
- ex_ready_o  output  1  LSU can accept an op
- addr_i  input  DATA_WIDTH  effective address
- wdata_i  input  DATA_WIDTH  store data (rs2)
- we_i  input  1  1=store, 0=load
- size_i  input  2  00 byte, 01 half, 10 word, 11 reserved
- unsigned_i  input  1  zero-extend load (LBU/LHU)
- rd_i  input  REG_ADDR_WIDTH  destination register tag
- data_req_o  output  1  memory request
- data_gnt_i  input  1  memory grant
- data_addr_o  output  DATA_WIDTH  word-aligned address (bits [1:0]=0)
- data_we_o  output  1  write enable
- data_be_o  output  DATA_WIDTH/8  byte enables
- data_wdata_o  output  DATA_WIDTH  lane-replicated store data
- data_rvalid_i  input  1  response valid
- data_rdata_i  input  DATA_WIDTH  read data
- data_err_i  input  1  bus error, qualified by rvalid
- wb_valid_o  output  1  one-cycle completion pulse
- wb_load_o  output  1  completed op was a load
- wb_rdata_o  output  DATA_WIDTH  extended load data
- wb_rd_o  output  REG_ADDR_WIDTH  destination tag
- wb_err_o  output  1  access faulted

Behaviour:
- Reset values: ex_ready_o=1, data_req_o=0, all other outputs 0, state IDLE.
- Clocking: single clock clk_i; asynchronous active-low reset rst_ni.
- FSM IDLE->REQ->WAIT->IDLE. ex_ready_o=1 only in IDLE.
- IDLE, on ex_valid_i&ex_ready_o:
  - Register addr/wdata/we/size/unsigned/rd.
  - Compute be/aligned wdata.
  - Go to REQ.
- REQ:
  - data_req_o=1; address/we/be/wdata held stable until grant.
  - On data_gnt_i go to WAIT; otherwise stay in REQ indefinitely.
- WAIT:
  - data_req_o=0; on data_rvalid_i go to IDLE.
  - wb_* outputs are registered and asserted the following cycle.
  - rvalid seen outside WAIT is ignored.
- Minimum latency:
  - Accept at cycle N, data_req_o at N+1.
  - With gnt at N+1 and rvalid at N+2, wb_valid_o is asserted at N+3.
  - A new op can be accepted in the same cycle wb_valid_o is high.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Store data replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- Load extraction:
  - Shift rdata right by 8*addr[1:0], take 8/16/32 bits.
  - Sign-extend unless unsigned_i; unsigned_i is ignored for word.
- Stores: wb_valid_o=1, wb_load_o=0, wb_rdata_o=0.
- data_err_i with rvalid: wb_err_o=1, wb_rdata_o=0.
- Misaligned access is defined as: half with addr[0]=1, word with addr[1:0]!=0, or size 11. Handling is per the optional feature.
- Reset mid-operation:
  - Immediate return to IDLE; data_req_o drops asynchronously.
  - No wb_valid_o pulse for the aborted op; a late rvalid is ignored.

Optional Feature:
- Macro: CORE_LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned op is accepted but no memory request is issued.
  - Next cycle: wb_valid_o=1, wb_err_o=1, wb_rdata_o=0, FSM stays in IDLE.
- Undefined:
  - Address is force-aligned to the access size (half clears bit0, word/reserved clear [1:0]; reserved size treated as word).
  - Access proceeds normally with wb_err_o=0.

Decomposition:
- Package core_lsu_pkg holds:
  - lsu_size_e enum (LSU_BYTE, LSU_HALF, LSU_WORD)
  - lsu_state_e (IDLE, REQ, WAIT)
  - Functions for misalignment check, be generation, store replication.
- Sub-module core_lsu_align (combinational) performs load data shift and extension; the top holds the FSM and registers.

Test Plan:
- SB, addr 0x1003, wdata 0x000000AB, gnt immediate -> data_addr_o=0x1000, data_be_o=4'b1000, data_wdata_o=0xABABABAB, wb_valid_o=1 with wb_load_o=0 at N+3.
- LH, addr 0x2002, rdata 0x8001_1234 -> wb_rdata_o=0xFFFF8001; same op as LHU -> 0x00008001.
- LW, gnt held low 5 cycles -> data_req_o, addr and be stable for all 5 cycles; ex_ready_o=0 throughout; single wb_valid_o pulse after rvalid.
- LW at 0x3000 with data_err_i=1 on rvalid -> wb_err_o=1, wb_rdata_o=0, wb_rd_o=original tag.
- LW at 0x4001 -> macro defined: no data_req_o, wb_err_o=1 next cycle; undefined: data_addr_o=0x4000, be=4'b1111, wb_err_o=0.
- Assert rst_ni low while in REQ -> data_req_o=0 immediately, state IDLE, later rvalid produces no wb_valid_o.
